// File: rtl/unlock_pkg.sv
// Shared definitions for the unlock sequencer: FSM state type, default sequence
// length, the ASCII key table used by the key matcher, and a counter-width helper.
package unlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OPEN    = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int N_STAGES_DEFAULT = 19;
  localparam int PROG_W           = 5;
  localparam int FAIL_W           = 2;

  // Key "S4t_s01veR_i5_Gr9a7", position k drives unlock[k] in the matcher.
  localparam logic [7:0] KEY_TABLE [N_STAGES_DEFAULT] = '{
    8'd83,  8'd52,  8'd116, 8'd95,  8'd115, 8'd48,  8'd49,  8'd118,
    8'd101, 8'd82,  8'd95,  8'd105, 8'd53,  8'd95,  8'd71,  8'd114,
    8'd57,  8'd97,  8'd55
  };

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unlock_sequencer_timer.sv
// Loadable down-counter: load sets CYCLES-1, en decrements toward zero, done
// is high while the count is zero.
module lockout_timer
  import unlock_pkg::*;
#(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int W = cnt_width(CYCLES);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/unlock_sequencer.sv
// Key-sequence unlock FSM fed by the external matcher's one-hot unlock vector.
// Optional idle timeout in COLLECT is enabled by defining SEQ_TIMEOUT_EN.
module unlock_sequencer
  import unlock_pkg::*;
#(
  parameter int N_STAGES       = N_STAGES_DEFAULT,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_STAGES-1:0] unlock,
  input  logic                relock,
  output logic [PROG_W-1:0]   progress,
  output logic                unlocked,
  output logic                locked,
  output logic                fail_pulse,
  output logic [FAIL_W-1:0]   fail_count
);

  if (N_STAGES < 1 || N_STAGES > 31 || MAX_FAILS < 1 || MAX_FAILS > 3 ||
      LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("unlock_sequencer: parameter out of range");
  end

  state_t              state, state_nxt;
  logic [PROG_W-1:0]   progress_nxt, prog_inc;
  logic [FAIL_W-1:0]   fail_count_nxt, fail_inc;
  logic                fail_pulse_nxt;
  logic                accept, key_ok, is_fail;
  logic                lock_load, lock_done;

  assign in_ready = (state == IDLE) || (state == COLLECT);
  assign accept   = in_valid && in_ready;
  // Only the bit at the current position matters; duplicate characters elsewhere are ignored.
  assign key_ok   = (progress < PROG_W'(N_STAGES)) && unlock[progress];
  assign prog_inc = progress + PROG_W'(1);
  assign fail_inc = (fail_count == FAIL_W'(MAX_FAILS)) ? fail_count : fail_count + FAIL_W'(1);

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
    .clk  (clk),
    .rst  (rst),
    .load (lock_load),
    .en   (state == LOCKED),
    .done (lock_done)
  );

`ifdef SEQ_TIMEOUT_EN
  logic idle_done;

  lockout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   ((state == COLLECT) && !accept),
    .done (idle_done)
  );
`endif

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    progress_nxt   = progress;
    fail_count_nxt = fail_count;
    fail_pulse_nxt = 1'b0;
    lock_load      = 1'b0;
    is_fail        = 1'b0;

    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          if (key_ok) begin
            progress_nxt = prog_inc;
            state_nxt    = (prog_inc == PROG_W'(N_STAGES)) ? OPEN : COLLECT;
          end else begin
            is_fail = 1'b1;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        // An accept on the expiry cycle takes priority over the timeout.
        else if ((state == COLLECT) && idle_done) begin
          is_fail = 1'b1;
        end
`endif
      end
      OPEN: begin
        if (relock) begin
          state_nxt      = IDLE;
          progress_nxt   = '0;
          fail_count_nxt = '0;
        end
      end
      LOCKED: begin
        progress_nxt = '0;
        if (lock_done) begin
          state_nxt      = IDLE;
          fail_count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (is_fail) begin
      progress_nxt   = '0;
      fail_pulse_nxt = 1'b1;
      fail_count_nxt = fail_inc;
      if (fail_inc == FAIL_W'(MAX_FAILS)) begin
        state_nxt = LOCKED;
        lock_load = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      progress   <= '0;
      fail_count <= '0;
      fail_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      progress   <= progress_nxt;
      fail_count <= fail_count_nxt;
      fail_pulse <= fail_pulse_nxt;
    end
  end

  assign unlocked = (state == OPEN);
  assign locked   = (state == LOCKED);

endmodule

// File: tb/tb_unlock_sequencer.sv
// Self-checking bench for unlock_sequencer: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model of the lock.
module tb_unlock_sequencer;
  import unlock_pkg::*;

  localparam int N    = N_STAGES_DEFAULT;
  localparam int MAXF = 3;
  localparam int LOCK = 1024;
  localparam int TMO  = 256;
  localparam logic [10:0] RESET_VEC = 11'b00000_0_0_0_00_1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         relock = 1'b0;
  logic [N-1:0] unlock = '0;
  logic         in_ready, unlocked, locked, fail_pulse;
  logic [4:0]   progress;
  logic [1:0]   fail_count;

  unlock_sequencer #(
    .N_STAGES(N), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .unlock(unlock), .relock(relock), .progress(progress), .unlocked(unlocked),
    .locked(locked), .fail_pulse(fail_pulse), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  string key_str = "S4t_s01veR_i5_Gr9a7";

  // Behavioural model: correct-key count, open flag, lockout cycles remaining.
  int m_prog, m_fails, m_lock_left, m_idle;
  bit m_open, m_pulse;

  function automatic logic [N-1:0] match(input logic [7:0] k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (k == 8'(key_str[i]));
    return r;
  endfunction

  function automatic logic [10:0] exp_vec();
    return {5'(m_prog), m_open, (m_lock_left > 0), m_pulse, 2'(m_fails),
            (!m_open && m_lock_left == 0)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {progress, unlocked, locked, fail_pulse, fail_count, in_ready};
  endfunction

  task automatic model_reset();
    m_prog = 0; m_fails = 0; m_lock_left = 0; m_idle = 0; m_open = 0; m_pulse = 0;
  endtask

  task automatic model_fail();
    m_prog  = 0;
    m_idle  = 0;
    m_pulse = 1;
    if (m_fails < MAXF) m_fails++;
    if (m_fails == MAXF) m_lock_left = LOCK;
  endtask

  task automatic model_step(input bit v, input logic [7:0] k, input bit r);
    m_pulse = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open) begin
      if (r) begin m_open = 0; m_prog = 0; m_fails = 0; end
    end else if (v) begin
      m_idle = 0;
      if (k == 8'(key_str[m_prog])) begin
        m_prog++;
        if (m_prog == N) m_open = 1;
      end else begin
        model_fail();
      end
    end
`ifdef SEQ_TIMEOUT_EN
    else if (m_prog > 0) begin
      m_idle++;
      if (m_idle == TMO) model_fail();
    end
`endif
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic step(input bit v, input logic [7:0] k, input bit r);
    in_valid = v;
    relock   = r;
    unlock   = v ? match(k) : N'($urandom);
    model_step(v, k, r);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    relock = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++; $display("FAIL reset_state: got=%b want=%b", dut_vec(), RESET_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_key();
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      step(1'b1, 8'(key_str[i]), 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_key[%0d]: got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if ({progress, unlocked, in_ready} !== {5'd19, 1'b1, 1'b0}) begin
      bad++; $display("FAIL full_key_open: got prog=%0d unl=%b rdy=%b want 19 1 0",
                      progress, unlocked, in_ready);
    end
  endtask

  task automatic test_wrong_char();
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    step(1'b1, 8'd120, 1'b0);
    total++;
    if ({fail_pulse, progress, fail_count, in_ready} !== {1'b1, 5'd0, 2'd1, 1'b1}) begin
      bad++; $display("FAIL wrong_char: got pulse=%b prog=%0d fc=%0d rdy=%b want 1 0 1 1",
                      fail_pulse, progress, fail_count, in_ready);
    end
    step(1'b0, 8'd0, 1'b0);
    total++;
    if (fail_pulse !== 1'b0) begin
      bad++; $display("FAIL wrong_char_pulse_width: got=%b want=0", fail_pulse);
    end
    for (int i = 0; i < N; i++) begin
      step(1'b1, 8'(key_str[i]), 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL wrong_char_retry[%0d]: got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (unlocked !== 1'b1) begin
      bad++; $display("FAIL wrong_char_unlock: got=%b want=1", unlocked);
    end
  endtask

  task automatic test_lockout();
    int n;
    pulse_reset();
    for (int i = 0; i < MAXF; i++) begin
      step(1'b1, 8'd0, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL lockout_fail[%0d]: got=%b want=%b", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if ({locked, fail_count} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL lockout_enter: got locked=%b fc=%0d want 1 3", locked, fail_count);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      n++;
      step(1'b0, 8'd0, (n == 100) || (n == 1023));
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL lockout_cycle[%0d]: got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    total++;
    if (n != LOCK) begin
      bad++; $display("FAIL lockout_length: got=%0d want=%0d", n, LOCK);
    end
    total++;
    if ({fail_count, locked, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL lockout_exit: got fc=%0d locked=%b rdy=%b want 0 0 1",
                      fail_count, locked, in_ready);
    end
    for (int i = 0; i < N; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    total++;
    if (unlocked !== 1'b1) begin
      bad++; $display("FAIL lockout_then_unlock: got=%b want=1", unlocked);
    end
  endtask

  task automatic test_relock();
    pulse_reset();
    for (int i = 0; i < N; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    step(1'b1, 8'd0, 1'b0);
    total++;
    if ({unlocked, progress, fail_pulse} !== {1'b1, 5'd19, 1'b0}) begin
      bad++; $display("FAIL open_ignores_input: got unl=%b prog=%0d pulse=%b want 1 19 0",
                      unlocked, progress, fail_pulse);
    end
    step(1'b0, 8'd0, 1'b1);
    total++;
    if ({unlocked, progress, in_ready} !== {1'b0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL relock: got unl=%b prog=%0d rdy=%b want 0 0 1",
                      unlocked, progress, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    step(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    total++;
    if ({progress, fail_count} !== {5'd10, 2'd1}) begin
      bad++; $display("FAIL mid_progress: got prog=%0d fc=%0d want 10 1", progress, fail_count);
    end
    rst = 1'b1;
    #2;
    model_reset();
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++; $display("FAIL mid_reset_async: got=%b want=%b", dut_vec(), RESET_VEC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    total++;
    if (dut_vec() !== exp_vec() || unlocked !== 1'b1) begin
      bad++; $display("FAIL mid_reset_unlock: got=%b want=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit         v, r;
    logic [7:0] k;
    pulse_reset();
    for (int c = 0; c < 5000; c++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 16) == 0;
      k = (($urandom % 8) != 0) ? 8'(key_str[(m_prog < N) ? m_prog : 0]) : 8'($urandom);
      step(v, k, r);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    for (int i = 0; i < TMO; i++) step(1'b0, 8'd0, 1'b0);
    total++;
    if ({fail_pulse, progress, fail_count} !== {1'b1, 5'd0, 2'd1}) begin
      bad++; $display("FAIL timeout_fire: got pulse=%b prog=%0d fc=%0d want 1 0 1",
                      fail_pulse, progress, fail_count);
    end
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(key_str[i]), 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'(key_str[4]), 1'b0);
    total++;
    if ({fail_pulse, progress, fail_count} !== {1'b0, 5'd5, 2'd0}) begin
      bad++; $display("FAIL timeout_edge_accept: got pulse=%b prog=%0d fc=%0d want 0 5 0",
                      fail_pulse, progress, fail_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_full_key();
    test_wrong_char();
    test_lockout();
    test_relock();
    test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
